// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings and the default width.
// The control unit reuses the op encodings when decoding funct 0x18..0x1B.
package multdiv_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Returns the next accumulator/remainder and the bit that shifts into the Q register.
module multdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_opd,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_bit
);

  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_shl;
  logic [WIDTH:0] w_diff;

  assign w_add  = {1'b0, i_acc} + (i_bit ? {1'b0, i_opd} : '0);
  assign w_shl  = {i_acc, i_bit};
  assign w_diff = w_shl - {1'b0, i_opd};

  // Divide: a set MSB on the difference is a borrow, so keep the shifted remainder.
  always_comb begin
    if (i_div) begin
      o_bit = ~w_diff[WIDTH];
      o_acc = w_diff[WIDTH] ? w_shl[WIDTH-1:0] : w_diff[WIDTH-1:0];
    end else begin
      o_bit = w_add[0];
      o_acc = w_add[WIDTH:1];
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Operates on magnitudes for WIDTH cycles, then applies sign correction in FINISH.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           r_state;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_divz;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_opd;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  op_e                w_op;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_step_acc;
  logic               w_step_bit;
  logic               w_step_in;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_neg;

  assign w_op    = op_e'(op);
  assign w_sa    = op_is_signed(w_op) & srca[WIDTH-1];
  assign w_sb    = op_is_signed(w_op) & srcb[WIDTH-1];
  assign w_mag_a = w_sa ? -srca : srca;
  assign w_mag_b = w_sb ? -srcb : srcb;

  // Multiply consumes Q from the LSB end; divide feeds the remainder from the MSB end.
  assign w_step_in  = r_div ? r_q[WIDTH-1] : r_q[0];
  assign w_prod     = {r_acc, r_q};
  assign w_prod_neg = -w_prod;

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div (r_div),
    .i_acc (r_acc),
    .i_bit (w_step_in),
    .i_opd (r_opd),
    .o_acc (w_step_acc),
    .o_bit (w_step_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_divz  <= 1'b0;
      r_cnt   <= '0;
      r_opd   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_div   <= op_is_div(w_op);
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_divz  <= op_is_div(w_op) & (srcb == '0);
            r_q     <= w_mag_a;
            r_opd   <= w_mag_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_acc <= w_step_acc;
          r_q   <= r_div ? {r_q[WIDTH-2:0], w_step_bit} : {w_step_bit, r_q[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FINISH;
        end
        S_FINISH: begin
          // Remainder follows the dividend's sign; a zero divisor forces an all-ones quotient.
          if (r_div) begin
            r_lo <= r_divz ? '1 : (r_neg_q ? -r_q : r_q);
            r_hi <= r_neg_r ? -r_acc : r_acc;
          end else begin
            {r_hi, r_lo} <= r_neg_q ? w_prod_neg : w_prod;
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed cases plus randomized traffic against a cycle-level arithmetic model.
module tb_multdiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start, hi_we, lo_we;
  logic [1:0]    op;
  logic [W-1:0]  srca, srcb, wdata;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  multdiv_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, from plain 64-bit arithmetic.
  task automatic model_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb, ua, ub;
    logic [63:0] t, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      2'b00: begin t = sa * sb; rh = t[63:32]; rl = t[31:0]; end
      2'b01: begin t = ua * ub; rh = t[63:32]; rl = t[31:0]; end
      default: begin
        if (b == 32'd0) begin
          rl = 32'hFFFF_FFFF;
          rh = a;
        end else if (o == 2'b10) begin
          t = sa / sb; r = sa % sb; rl = t[31:0]; rh = r[31:0];
        end else begin
          t = ua / ub; r = ua % ub; rl = t[31:0]; rh = r[31:0];
        end
      end
    endcase
  endtask

  // Cycle-level model: an accepted op keeps the unit busy for W+1 cycles, then lands in HI/LO.
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_rhi; m_lo = m_rlo; m_done = 1'b1;
      end
    end else if (start) begin
      model_calc(op, srca, srcb, m_rhi, m_rlo);
      m_left = W + 1;
    end else begin
      if (hi_we) m_hi = wdata;
      if (lo_we) m_lo = wdata;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int bcyc);
    bcyc = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy) bcyc++;
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc, cnt;
    reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", bc);
    chk("multu_max_busy_cycles", 32'(bc), 32'd33);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);

    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_neg", bc);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFF1);

    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min", bc);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", bc);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    issue(2'b11, 32'd7, 32'd2);
    wait_done("divu", bc);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_wrap", bc);
    chk("div_wrap_lo", lo, 32'h8000_0000);
    chk("div_wrap_hi", hi, 32'h0);

    issue(2'b11, 32'd100, 32'd0);
    wait_done("divu_zero", bc);
    chk("divu_zero_busy_cycles", 32'(bc), 32'd33);
    chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi", hi, 32'd100);

    issue(2'b10, 32'hFFFF_FF9C, 32'd0);
    wait_done("div_zero", bc);
    chk("div_zero_lo", lo, 32'hFFFF_FFFF);
    chk("div_zero_hi", hi, 32'hFFFF_FF9C);

    // Start while busy is ignored; later reset aborts without a done pulse.
    issue(2'b01, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    issue(2'b01, 32'd100, 32'd100);
    wait_done("ignored_start", bc);
    chk("ignored_start_lo", lo, 32'd42);
    chk("ignored_start_hi", hi, 32'd0);
    count_dones(40, cnt);
    chk("no_second_done", 32'(cnt), 32'd0);

    issue(2'b00, 32'h1234, 32'd5);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    count_dones(40, cnt);
    chk("abort_no_done", 32'(cnt), 32'd0);

    // MTHI/MTLO in idle, while busy, and alongside start.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_idle_hi", hi, 32'h1234_5678);
    chk("mt_idle_lo", lo, 32'h1234_5678);

    issue(2'b01, 32'd2, 32'd3);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_busy_hi", hi, 32'h1234_5678);
    chk("mt_busy_lo", lo, 32'h1234_5678);
    wait_done("mt_busy_op", bc);
    chk("mt_busy_op_lo", lo, 32'd6);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_5555;
    issue(2'b01, 32'd1, 32'd1);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_start_hi", hi, 32'd0);
    chk("mt_start_lo", lo, 32'd6);
    wait_done("mt_start_op", bc);
    chk("mt_start_op_lo", lo, 32'd1);

    // Randomized traffic; the per-cycle compare process checks everything.
    for (int i = 0; i < 6000; i++) begin
      start = ($urandom % 4) == 0;
      op    = 2'($urandom % 4);
      srca  = pick();
      srcb  = pick();
      hi_we = ($urandom % 8) == 0;
      lo_we = ($urandom % 8) == 0;
      wdata = $urandom;
      reset = ($urandom % 500) == 0;
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
